// File: rtl/me_pkg.sv
// Shared motion-estimation constants and the SAD-stage state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package me_pkg;

  localparam int BLK_PIX   = 256;
  localparam int NUM_CAND  = 32;
  localparam int ALIGN_DLY = 16;
  localparam int SAD_W     = 16;
  localparam int IDX_W     = 5;

  // Candidate index is {pair, lane}, so the pair counter is one bit narrower.
  localparam int PAIR_W = IDX_W - 1;
  // One counter serves both the align delay and the pixel position.
  localparam int CNT_W  = $clog2((BLK_PIX > ALIGN_DLY) ? BLK_PIX : ALIGN_DLY);

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_ALIGN_ENC = 3'd1;
  localparam logic [2:0] ST_ACCUM_ENC = 3'd2;
  localparam logic [2:0] ST_FLUSH_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ALIGN = ST_ALIGN_ENC,
    ST_ACCUM = ST_ACCUM_ENC,
    ST_FLUSH = ST_FLUSH_ENC,
    ST_DONE  = ST_DONE_ENC
  } sad_state_e;

endpackage

// File: rtl/me_absdiff8.sv
// Unsigned 8-bit absolute difference |a-b|; optional output register (SAD_PIPE_EN).
// Latency: 0 cycles by default, 1 cycle with SAD_PIPE_EN.
// Backpressure: none; result is produced every cycle.
module me_absdiff8 (
`ifdef SAD_PIPE_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);

  logic [7:0] diff;

  assign diff = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

`ifdef SAD_PIPE_EN
  logic [7:0] y_q;

  // Register the difference to cut the subtract-add path.
  always_ff @(posedge clk) begin
    if (reset) y_q <= '0;
    else       y_q <= diff;
  end

  assign y_o = y_q;
`else
  assign y_o = diff;
`endif

endmodule

// File: rtl/me_sad_min_search.sv
// Two-lane SAD accumulation with running minimum over all candidates; SAD_PIPE_EN adds an abs-diff register.
// Latency: done in cycle ALIGN_DLY+(NUM_CAND/2)*BLK_PIX+2 after start (+1 with SAD_PIPE_EN).
// Backpressure: none; pixels are consumed every ACCUM cycle, start is ignored unless idle.
module me_sad_min_search
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       c,
  input  logic [7:0]       p,
  input  logic [7:0]       p_prime,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
);

  localparam logic [CNT_W-1:0]  ALIGN_LAST = CNT_W'(ALIGN_DLY - 1);
  localparam logic [CNT_W-1:0]  PIX_LAST   = CNT_W'(BLK_PIX - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST  = PAIR_W'(NUM_CAND / 2 - 1);

  sad_state_e        state_q, state_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [PAIR_W-1:0] pair_cnt_q, pair_cnt_d;
  logic [SAD_W-1:0]  acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [SAD_W-1:0]  best_q, best_d;
  logic [IDX_W-1:0]  best_cand_q, best_cand_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;

  logic [7:0]        diff_a, diff_b;
  logic              smp_vld, smp_last, search_go;
  logic              acc_vld, acc_last, pipe_busy;
  logic [PAIR_W-1:0] acc_pair;
  logic [SAD_W-1:0]  sum_a, sum_b, pick_sad;
  logic              pick_b;
  logic [IDX_W-1:0]  pick_idx;

  me_absdiff8 u_absdiff_a (
`ifdef SAD_PIPE_EN
    .clk   (clk),
    .reset (reset),
`endif
    .a_i   (c),
    .b_i   (p),
    .y_o   (diff_a)
  );

  me_absdiff8 u_absdiff_b (
`ifdef SAD_PIPE_EN
    .clk   (clk),
    .reset (reset),
`endif
    .a_i   (c),
    .b_i   (p_prime),
    .y_o   (diff_b)
  );

  assign search_go = (state_q == ST_IDLE) && start;
  assign smp_vld   = (state_q == ST_ACCUM);
  assign smp_last  = smp_vld && (pix_cnt_q == PIX_LAST);

`ifdef SAD_PIPE_EN
  logic              acc_vld_q, acc_last_q;
  logic [PAIR_W-1:0] acc_pair_q;

  // Delay the sample qualifiers to line up with the registered differences.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_vld_q  <= 1'b0;
      acc_last_q <= 1'b0;
      acc_pair_q <= '0;
    end else begin
      acc_vld_q  <= smp_vld;
      acc_last_q <= smp_last;
      acc_pair_q <= pair_cnt_q;
    end
  end

  assign acc_vld   = acc_vld_q;
  assign acc_last  = acc_last_q;
  assign acc_pair  = acc_pair_q;
  assign pipe_busy = acc_vld_q;
`else
  assign acc_vld   = smp_vld;
  assign acc_last  = smp_last;
  assign acc_pair  = pair_cnt_q;
  assign pipe_busy = 1'b0;
`endif

  // FSM next state plus align/pixel/pair counters.
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    pair_cnt_d = pair_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ALIGN;
          pix_cnt_d  = '0;
          pair_cnt_d = '0;
        end
      end
      ST_ALIGN: begin
        if (pix_cnt_q == ALIGN_LAST) begin
          pix_cnt_d = '0;
          state_d   = ST_ACCUM;
        end else begin
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end
      end
      ST_ACCUM: begin
        if (pix_cnt_q == PIX_LAST) begin
          pix_cnt_d  = '0;
          pair_cnt_d = pair_cnt_q + PAIR_W'(1);
          if (pair_cnt_q == PAIR_LAST) state_d = ST_FLUSH;
        end else begin
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end
      end
      // Hold here until the optional difference register has drained.
      ST_FLUSH: if (!pipe_busy) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign sum_a    = acc_a_q + {{(SAD_W-8){1'b0}}, diff_a};
  assign sum_b    = acc_b_q + {{(SAD_W-8){1'b0}}, diff_b};
  assign pick_b   = (sum_b < sum_a);          // a wins a tie
  assign pick_sad = pick_b ? sum_b : sum_a;
  assign pick_idx = {acc_pair, pick_b};

  // Accumulate both lanes; at pair end fold the winner into the running minimum.
  always_comb begin
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    best_d      = best_q;
    best_cand_d = best_cand_q;
    best_sad_d  = best_sad_q;
    best_idx_d  = best_idx_q;
    if (search_go) begin
      acc_a_d     = '0;
      acc_b_d     = '0;
      best_d      = '1;
      best_cand_d = '0;
    end else if (acc_vld) begin
      if (acc_last) begin
        acc_a_d = '0;
        acc_b_d = '0;
        // Strict compare keeps the earliest (lowest index) candidate on ties.
        if (pick_sad < best_q) begin
          best_d      = pick_sad;
          best_cand_d = pick_idx;
        end
      end else begin
        acc_a_d = sum_a;
        acc_b_d = sum_b;
      end
    end
    if ((state_q == ST_FLUSH) && (state_d == ST_DONE)) begin
      best_sad_d = best_q;
      best_idx_d = best_cand_q;
    end
  end

  // State, counters, accumulators and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      pair_cnt_q  <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      best_q      <= '1;
      best_cand_q <= '0;
      best_sad_q  <= '0;
      best_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      pair_cnt_q  <= pair_cnt_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      best_q      <= best_d;
      best_cand_q <= best_cand_d;
      best_sad_q  <= best_sad_d;
      best_idx_q  <= best_idx_d;
    end
  end

  assign busy     = (state_q == ST_ALIGN) || (state_q == ST_ACCUM) || (state_q == ST_FLUSH);
  assign done     = (state_q == ST_DONE);
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

endmodule
